// File: rtl/ysyx_24080006_mdu.sv
// ---------------------------------------------------------------------------
// ysyx_24080006_mdu -- iterative RV32M multiply/divide unit (execute stage)
//
// Purpose:
//   Takes the decoder's mdu_set_t bundle and the rs1/rs2 operands, and
//   computes MUL/MULH/MULHSU/MULHU with a radix-2 shift-add multiplier. It
//   computes DIV/DIVU/REM/REMU with a restoring divider. The 32-bit result
//   goes to writeback through a valid/ready handshake.
//
// Ports:
//   clock, reset   system clock; asynchronous active-high reset
//   flush_i        abort any operation; the unit is IDLE after the next edge
//   valid_i        EX presents an instruction (qualified by mdu_enable)
//   ready_o        unit can accept (IDLE)
//   mdu_set_i      {mdu_enable, signed_a, signed_b, mdu_op}
//   rs1_i, rs2_i   operands a and b
//   valid_o        result available (DONE)
//   ready_i        downstream consumes the result
//   result_o       result, stable while valid_o && !ready_i
//   busy_o         unit is not IDLE (EX stall)
//   dbg_state_o    current FSM state, for observation only
//
// Handshake:
//   Input side: a transfer happens on a rising edge where
//   valid_i && mdu_set_i.mdu_enable && ready_o && !flush_i.
//   Output side: a transfer happens on a rising edge where valid_o && ready_i.
//   After valid_o rises, it stays high and result_o stays unchanged until that
//   output transfer happens, or until a flush or reset.
// ---------------------------------------------------------------------------
package ysyx_24080006_mdu_pkg;

  typedef enum logic [1:0] {
    ALU_MULL = 2'd0,
    ALU_MULH = 2'd1,
    ALU_DIV  = 2'd2,
    ALU_REM  = 2'd3
  } mdu_op_e;

  typedef struct packed {
    logic    mdu_enable;
    logic    signed_a;
    logic    signed_b;
    mdu_op_e mdu_op;
  } mdu_set_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } mdu_state_e;

endpackage

module ysyx_24080006_mdu
  import ysyx_24080006_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  mdu_set_t        mdu_set_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o,
  output mdu_state_e      dbg_state_o
);

  localparam int AW = XLEN + 1;      // extended operand width
  localparam int PW = 2 * XLEN + 2;  // product accumulator width

  mdu_state_e r_state;
  mdu_state_e w_next;

  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_mcand;
  logic [AW-1:0]   r_mplier;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_div;
  logic [XLEN-1:0] r_result;
  logic [5:0]      r_cnt;
  logic            r_is_mulh;
  logic            r_is_rem;
  logic            r_neg_q;
  logic            r_neg_r;

  // ---------------------------------------------------------------- accept
  logic [AW-1:0]   w_a33;
  logic [AW-1:0]   w_b33;
  logic            w_accept;
  logic            w_is_mul;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_spec_res;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;

  assign w_a33 = {mdu_set_i.signed_a & rs1_i[XLEN-1], rs1_i};
  assign w_b33 = {mdu_set_i.signed_b & rs2_i[XLEN-1], rs2_i};

  assign w_accept = valid_i && mdu_set_i.mdu_enable && (r_state == S_IDLE) && !flush_i;
  assign w_is_mul = (mdu_set_i.mdu_op == ALU_MULL) || (mdu_set_i.mdu_op == ALU_MULH);

  // Divide-by-zero and signed overflow are resolved at accept. The iterative
  // datapath does not give the RISC-V defined results for these cases.
  assign w_div0    = (rs2_i == '0);
  assign w_ovf     = mdu_set_i.signed_a && mdu_set_i.signed_b &&
                     (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == {XLEN{1'b1}});
  assign w_special = !w_is_mul && (w_div0 || w_ovf);

  always_comb begin
    w_spec_res = '0;
    if (mdu_set_i.mdu_op == ALU_REM) begin
      w_spec_res = w_div0 ? rs1_i : '0;
    end else begin
      w_spec_res = w_div0 ? {XLEN{1'b1}} : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // The divider works on magnitudes. Sign correction happens in FIX.
  assign w_abs_a = w_a33[XLEN] ? -rs1_i : rs1_i;
  assign w_abs_b = w_b33[XLEN] ? -rs2_i : rs2_i;

  // ------------------------------------------------------------ multiplier
  // The last step (cnt==32) subtracts, because bit 32 of b33 carries negative
  // weight in two's complement.
  logic [PW-1:0]   w_mul_add;
  logic [PW-1:0]   w_acc_next;
  logic [XLEN-1:0] w_mul_res;

  assign w_mul_add  = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = (r_cnt == 6'd32) ? (r_acc - w_mul_add) : (r_acc + w_mul_add);
  assign w_mul_res  = r_is_mulh ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];

  // --------------------------------------------------------------- divider
  // Restoring step. The shifted partial remainder can need XLEN+1 bits. When
  // it is >= divisor, the difference always fits in XLEN bits.
  logic [AW-1:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_sub;
  logic [XLEN-1:0] w_rem_next;
  logic [XLEN-1:0] w_quo_next;

  assign w_shift    = {r_rem, r_quo[XLEN-1]};
  assign w_ge       = (w_shift >= {1'b0, r_div});
  assign w_sub      = w_shift[XLEN-1:0] - r_div;
  assign w_rem_next = w_ge ? w_sub : w_shift[XLEN-1:0];
  assign w_quo_next = {r_quo[XLEN-2:0], w_ge};

  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;
  logic [XLEN-1:0] w_fix_res;

  assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fix = r_neg_r ? -r_rem : r_rem;
  assign w_fix_res = r_is_rem ? w_rem_fix : w_quo_fix;

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (flush_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mul)       w_next = S_MUL;
            else if (w_special) w_next = S_DONE;
            else                w_next = S_DIV;
          end
        end
        S_MUL:   if (r_cnt == 6'd32) w_next = S_DONE;
        S_DIV:   if (r_cnt == 6'd31) w_next = S_FIX;
        S_FIX:   w_next = S_DONE;
        S_DONE:  if (ready_i) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  assign ready_o     = (r_state == S_IDLE);
  assign busy_o      = (r_state != S_IDLE);
  assign valid_o     = (r_state == S_DONE);
  assign result_o    = r_result;
  assign dbg_state_o = r_state;

  // The result register loads only on entry to DONE. A flush redirects
  // w_next to IDLE, so a flushed operation never updates the result.
  logic            w_enter_done;
  logic [XLEN-1:0] w_done_res;

  assign w_enter_done = (w_next == S_DONE) && (r_state != S_DONE);

  always_comb begin
    w_done_res = w_spec_res;
    case (r_state)
      S_MUL:   w_done_res = w_mul_res;
      S_FIX:   w_done_res = w_fix_res;
      default: w_done_res = w_spec_res;
    endcase
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_div     <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
      r_is_mulh <= 1'b0;
      r_is_rem  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc     <= '0;
        r_mcand   <= {{(PW-AW){w_a33[XLEN]}}, w_a33};
        r_mplier  <= w_b33;
        r_quo     <= w_abs_a;
        r_div     <= w_abs_b;
        r_rem     <= '0;
        r_cnt     <= '0;
        r_is_mulh <= (mdu_set_i.mdu_op == ALU_MULH);
        r_is_rem  <= (mdu_set_i.mdu_op == ALU_REM);
        r_neg_q   <= w_a33[XLEN] ^ w_b33[XLEN];
        r_neg_r   <= w_a33[XLEN];
      end else if (r_state == S_MUL) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 6'd1;
      end else if (r_state == S_DIV) begin
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
        r_cnt <= r_cnt + 6'd1;
      end
      if (w_enter_done) begin
        r_result <= w_done_res;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_mdu.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_24080006_mdu.
// Directed vectors with hand-computed results. The driver pushes the expected
// result and the expected first-valid cycle when an op is accepted. The
// monitor pops and compares them when valid_o rises and on each output
// handshake.
// Cycle convention: cyc counts rising edges. An op accepted on the edge that
// sets cyc=c, with latency L, must show valid_o in the cycle where cyc=c+L-1.
// ---------------------------------------------------------------------------
module tb_ysyx_24080006_mdu;
  import ysyx_24080006_mdu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b1;
  mdu_set_t    mdu_set_i = '0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic        ready_o;
  logic        valid_o;
  logic        busy_o;
  logic [31:0] result_o;
  mdu_state_e  dbg_state;

  ysyx_24080006_mdu #(.XLEN(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .mdu_set_i   (mdu_set_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .result_o    (result_o),
    .busy_o      (busy_o),
    .dbg_state_o (dbg_state)
  );

  // ---------------------------------------------------- clock / reset
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ------------------------------------------------------- scoreboard
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  int          checks = 0;
  int          failures = 0;
  int          n_done = 0;
  logic        prev_valid = 1'b0;
  int          mon_cyc;
  logic [31:0] mon_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Monitor: the latency check fires when valid_o rises, the result check on each output handshake.
  always @(negedge clock) begin
    if (!reset) begin
      if (valid_o && !prev_valid) begin
        if (exp_cyc_q.size() == 0) begin
          fail_now("unexpected_valid", "valid_o rose with no op outstanding");
        end else begin
          mon_cyc = exp_cyc_q.pop_front();
          check("valid_latency_cycle", 32'(cyc), 32'(mon_cyc));
        end
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_result", "handshake with empty expected queue");
        end else begin
          mon_res = exp_q.pop_front();
          check("result", result_o, mon_res);
        end
        n_done++;
      end
    end
    prev_valid = valid_o;
  end

  // ---------------------------------------------------------- drivers
  task automatic issue(input mdu_op_e op, input logic sa, input logic sb,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int lat,
                       input bit expect_it, output int acc_cyc);
    int guard;
    guard = 0;
    while (!ready_o && guard < 200) begin
      @(posedge clock); #1;
      guard++;
    end
    if (!ready_o) fail_now("ready_timeout", "ready_o never returned high");
    mdu_set_i = '{mdu_enable: 1'b1, signed_a: sa, signed_b: sb, mdu_op: op};
    rs1_i     = a;
    rs2_i     = b;
    valid_i   = 1'b1;
    @(posedge clock); #1;
    acc_cyc   = cyc;
    valid_i   = 1'b0;
    mdu_set_i.mdu_enable = 1'b0;
    rs1_i     = $urandom;
    rs2_i     = $urandom;
    if (expect_it) begin
      exp_q.push_back(exp_res);
      exp_cyc_q.push_back(acc_cyc + lat - 1);
    end
  endtask

  task automatic wait_done(input int target);
    int g;
    g = 0;
    while (n_done < target && g < 100) begin
      @(posedge clock); #1;
      g++;
    end
    if (n_done < target) fail_now("done_timeout", "no result handshake within 100 cycles");
  endtask

  task automatic run_op(input mdu_op_e op, input logic sa, input logic sb,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int lat);
    int n0;
    int c;
    n0 = n_done;
    issue(op, sa, sb, a, b, exp_res, lat, 1'b1, c);
    wait_done(n0 + 1);
  endtask

  // --------------------------------------------------------- stimulus
  initial begin
    int c;
    int n0;
    int g;

    repeat (3) @(posedge clock);
    #1;
    check("reset_valid_o", 32'(valid_o), 32'd0);
    check("reset_busy_o", 32'(busy_o), 32'd0);
    check("reset_ready_o", 32'(ready_o), 32'd1);
    check("reset_result_o", result_o, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Multiplies
    run_op(ALU_MULL, 1, 1, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op(ALU_MULH, 1, 1, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
    run_op(ALU_MULH, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op(ALU_MULH, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run_op(ALU_MULH, 0, 0, 32'h8000_0000, 32'd2,        32'h0000_0001, 34);
    run_op(ALU_MULL, 0, 0, 32'h8000_0000, 32'd2,        32'h0000_0000, 34);
    // Divides
    run_op(ALU_DIV,  0, 0, 32'd100,      32'd7,        32'd14,         34);
    run_op(ALU_REM,  0, 0, 32'd100,      32'd7,        32'd2,          34);
    run_op(ALU_DIV,  1, 1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34);
    run_op(ALU_REM,  1, 1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34);
    run_op(ALU_REM,  1, 1, 32'd7,        32'hFFFF_FFFE, 32'd1,          34);
    run_op(ALU_DIV,  1, 1, 32'd100,      32'hFFFF_FFF9, 32'hFFFF_FFF2, 34);
    run_op(ALU_DIV,  0, 0, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 34);
    // Special cases
    run_op(ALU_DIV,  1, 1, 32'd1234,     32'd0,        32'hFFFF_FFFF,  1);
    run_op(ALU_REM,  1, 1, 32'd5,        32'd0,        32'd5,          1);
    run_op(ALU_DIV,  1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op(ALU_REM,  1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // Backpressure: hold DONE for 10 cycles, then release with a new op already waiting
    ready_i = 1'b0;
    n0 = n_done;
    issue(ALU_DIV, 0, 0, 32'd100, 32'd7, 32'd14, 34, 1'b1, c);
    g = 0;
    while (!valid_o && g < 60) begin
      @(posedge clock); #1;
      g++;
    end
    if (!valid_o) fail_now("bp_valid_timeout", "valid_o never rose");
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      check("bp_result_stable", result_o, 32'd14);
      check("bp_ready_o_low", 32'(ready_o), 32'd0);
      check("bp_valid_held", 32'(valid_o), 32'd1);
    end
    ready_i   = 1'b1;
    mdu_set_i = '{mdu_enable: 1'b1, signed_a: 1'b1, signed_b: 1'b1, mdu_op: ALU_MULL};
    rs1_i     = 32'd7;
    rs2_i     = 32'hFFFF_FFFD;
    valid_i   = 1'b1;
    @(posedge clock); #1;
    // The DONE->IDLE edge must not also accept the op
    check("b2b_not_taken_in_done", 32'(ready_o), 32'd1);
    @(posedge clock); #1;
    valid_i = 1'b0;
    mdu_set_i.mdu_enable = 1'b0;
    check("b2b_taken_next", 32'(busy_o), 32'd1);
    exp_q.push_back(32'hFFFF_FFEB);
    exp_cyc_q.push_back(cyc + 33);
    wait_done(n0 + 2);

    // Flush at DIV iteration 15
    issue(ALU_DIV, 1, 1, 32'd100, 32'd7, 32'd0, 34, 1'b0, c);
    repeat (15) @(posedge clock);
    #1;
    flush_i = 1'b1;
    @(posedge clock); #1;
    flush_i = 1'b0;
    check("flush_valid_o", 32'(valid_o), 32'd0);
    check("flush_busy_o", 32'(busy_o), 32'd0);
    check("flush_state_idle", 32'(dbg_state), 32'(S_IDLE));
    repeat (40) @(posedge clock);
    #1;
    check("flush_no_late_valid", 32'(valid_o), 32'd0);
    check("flush_result_kept", result_o, 32'hFFFF_FFEB);

    // Async reset mid-MUL, sampled between clock edges
    issue(ALU_MULL, 1, 1, 32'd1234, 32'd5678, 32'd0, 34, 1'b0, c);
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("areset_valid_o", 32'(valid_o), 32'd0);
    check("areset_busy_o", 32'(busy_o), 32'd0);
    check("areset_ready_o", 32'(ready_o), 32'd1);
    check("areset_result_o", result_o, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    run_op(ALU_MULL, 1, 1, 32'd6, 32'd7, 32'd42, 34);

    repeat (5) @(posedge clock);
    #1;
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    fail_now("watchdog", "simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
